// File: rtl/disp_pkg.sv
// Shared definitions for the SPI display controller: FSM state encoding,
// display mode encodings and the hex-to-7-segment lookup table.
package disp_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] MODE_HEX     = 2'd0;  // hex digit to 7-segment
    localparam logic [1:0] MODE_RAW     = 2'd1;  // raw nibble, upper bits zero
    localparam logic [1:0] MODE_HEX_LZB = 2'd2;  // 7-segment with leading-zero blanking
    localparam logic [1:0] MODE_TEST    = 2'd3;  // every segment lit

    // Segment byte is {dp, g, f, e, d, c, b, a}, active-high, dp always off.
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    // Byte sent for one digit; blank is only honoured in blanking mode.
    function automatic logic [7:0] encode_digit(input logic [3:0] digit,
                                                input logic [1:0] mode,
                                                input logic       blank);
        logic [7:0] seg;
        case (mode)
            MODE_HEX:     seg = SEG_TABLE[digit];
            MODE_RAW:     seg = {4'h0, digit};
            MODE_HEX_LZB: seg = blank ? 8'h00 : SEG_TABLE[digit];
            default:      seg = 8'hFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/spi_shift_byte.sv
// One-byte SPI mode-0 shifter: generates sclk from clk, drives mosi MSB
// first and, when DISP_READBACK_EN is defined, captures miso on sclk rising.
module spi_shift_byte
    import disp_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] tx_byte,
    input  logic       run,
`ifdef DISP_READBACK_EN
    input  logic       miso,
    output logic [7:0] rx_byte,
`endif
    output logic       sclk,
    output logic       mosi,
    output logic       byte_last
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       tx_q, tx_d;
`ifdef DISP_READBACK_EN
    logic [7:0]       rx_q, rx_d;
`endif
    logic             tick;

    assign tick      = run && (div_q == DIV_LAST);
    // Final falling edge of bit 7: the controller loads the next byte here.
    assign byte_last = tick && sclk_q && (bit_q == 3'd7);
    assign sclk      = sclk_q;
    assign mosi      = tx_q[7];
`ifdef DISP_READBACK_EN
    assign rx_byte   = rx_q;
`endif

    // Next-state: half-period divider, sclk toggle, shift on falling edge.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        div_d  = div_q;
        sclk_d = sclk_q;
        bit_d  = bit_q;
        tx_d   = tx_q;
`ifdef DISP_READBACK_EN
        rx_d   = rx_q;
`endif
        if (run) begin
            if (tick) begin
                div_d  = '0;
                sclk_d = ~sclk_q;
                if (sclk_q) begin
                    // Falling edge: advance mosi while sclk goes low.
                    bit_d = bit_q + 3'd1;
                    tx_d  = {tx_q[6:0], 1'b0};
                end
`ifdef DISP_READBACK_EN
                else begin
                    rx_d = {rx_q[6:0], miso};
                end
`endif
            end else begin
                div_d = div_q + 1'b1;
            end
        end
        if (load) begin
            div_d  = '0;
            sclk_d = 1'b0;
            bit_d  = 3'd0;
            tx_d   = tx_byte;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            bit_q  <= 3'd0;
            tx_q   <= 8'h00;
`ifdef DISP_READBACK_EN
            rx_q   <= 8'h00;
`endif
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
            bit_q  <= bit_d;
            tx_q   <= tx_d;
`ifdef DISP_READBACK_EN
            rx_q   <= rx_d;
`endif
        end
    end

endmodule

// File: rtl/spi_disp_ctrl.sv
// SPI display controller: latches digits and mode into shadow registers and
// sends one frame of N_DIGITS encoded bytes, highest digit first.
// Optional macro DISP_READBACK_EN adds the rdata port holding the miso bits
// captured during the last completed frame.
module spi_disp_ctrl
    import disp_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int CLK_DIV  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set,
    input  logic [4*N_DIGITS-1:0] din,
    input  logic [1:0]            mode,
    input  logic                  start,
    output logic                  ss,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  busy,
    output logic                  done,
`ifdef DISP_READBACK_EN
    output logic [8*N_DIGITS-1:0] rdata,
`endif
    output logic [2:0]            state
);

    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FRAME_W = 8 * N_DIGITS;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N_DIGITS - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] din_q, din_d;
    logic [1:0]            mode_q, mode_d;
    logic                  done_q, done_d;
    logic                  ss_q, ss_d;

    logic                  load;
    logic [IDX_W-1:0]      load_idx;
    logic [3:0]            load_digit;
    logic [7:0]            tx_byte;
    logic                  byte_last;
    logic [N_DIGITS-1:0]   lz_blank;

`ifdef DISP_READBACK_EN
    logic [7:0]            rx_byte;
    logic [FRAME_W-1:0]    rx_frame_q, rx_frame_d;
    logic [FRAME_W-1:0]    rdata_q, rdata_d;
`else
    logic                  unused_miso;
    assign unused_miso = miso;
`endif

    assign ss    = ss_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign state = state_q;
`ifdef DISP_READBACK_EN
    assign rdata = rdata_q;
`endif

    // Leading-zero blanking: a digit blanks when it and all higher digits are 0.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lz_blank   = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            upper_zero  = upper_zero & (din_q[4*i +: 4] == 4'h0);
            lz_blank[i] = upper_zero && (i != 0);
        end
    end

    // Encode the digit about to be handed to the shifter.
    always_comb begin
        load_digit = din_q[4*load_idx +: 4];
        tx_byte    = encode_digit(load_digit, mode_q, lz_blank[load_idx]);
    end

    // FSM next-state, shadow update and byte sequencing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        din_d    = din_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        load     = 1'b0;
        load_idx = IDX_TOP;
        unique case (state_q)
            S_IDLE: begin
                if (set) begin
                    din_d  = din;
                    mode_d = mode;
                end
                if (start) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                end
            end
            S_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = S_SHIFT;
                    load    = 1'b1;
                    idx_d   = IDX_TOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                load_idx = idx_q - 1'b1;
                if (byte_last) begin
                    if (idx_q == '0) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else begin
                        load  = 1'b1;
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        ss_d = (state_d == S_IDLE);
    end

`ifdef DISP_READBACK_EN
    // Assemble received bytes, first byte ends up in the MSBs; publish on done.
    always_comb begin
        rx_frame_d = rx_frame_q;
        rdata_d    = rdata_q;
        if ((state_q == S_SHIFT) && byte_last) begin
            rx_frame_d = FRAME_W'({rx_frame_q, rx_byte});
        end
        if (done_d) begin
            rdata_d = rx_frame_q;
        end
    end

    // Readback registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_frame_q <= '0;
            rdata_q    <= '0;
        end else begin
            rx_frame_q <= rx_frame_d;
            rdata_q    <= rdata_d;
        end
    end
`endif

    // Controller registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            din_q   <= '0;
            mode_q  <= MODE_HEX;
            done_q  <= 1'b0;
            ss_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            din_q   <= din_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            ss_q    <= ss_d;
        end
    end

    spi_shift_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .tx_byte   (tx_byte),
        .run       (state_q == S_SHIFT),
`ifdef DISP_READBACK_EN
        .miso      (miso),
        .rx_byte   (rx_byte),
`endif
        .sclk      (sclk),
        .mosi      (mosi),
        .byte_last (byte_last)
    );

endmodule

// File: tb/tb_spi_disp_ctrl.sv
// Directed bench for spi_disp_ctrl with default parameters (4 digits,
// CLK_DIV 4). Frame bytes are collected from mosi on sclk rising edges.
module tb_spi_disp_ctrl;

    localparam int DONE_CYC = 265;

    logic        clk = 1'b0;
    logic        rst;
    logic        set;
    logic [15:0] din;
    logic [1:0]  mode;
    logic        start;
    logic        ss;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        busy;
    logic        done;
    logic [2:0]  state;
`ifdef DISP_READBACK_EN
    logic [31:0] rdata;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mon_word = '0;
    int          mon_bits = 0;
    logic [31:0] rx_pat   = '0;

    always #5 clk = ~clk;

    spi_disp_ctrl #(
        .N_DIGITS (4),
        .CLK_DIV  (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .set   (set),
        .din   (din),
        .mode  (mode),
        .start (start),
        .ss    (ss),
        .sclk  (sclk),
        .mosi  (mosi),
        .miso  (miso),
        .busy  (busy),
        .done  (done),
`ifdef DISP_READBACK_EN
        .rdata (rdata),
`endif
        .state (state)
    );

    // Slave model: presents rx_pat MSB first, advancing after each rising sclk.
    assign miso = (mon_bits < 32) ? rx_pat[5'(31 - mon_bits)] : 1'b0;

    // Frame monitor: restart on ss falling, sample mosi on sclk rising.
    always @(posedge sclk or negedge ss) begin
        if (!sclk) begin
            mon_word = '0;
            mon_bits = 0;
        end else if (!ss) begin
            mon_word = {mon_word[30:0], mosi};
            mon_bits = mon_bits + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Launch a frame from a point 1ns after a rising edge; optionally inject a
    // start and/or a set (din=inj_din, mode 0) at given cycles during the frame.
    task automatic run_frame(input string tag, input logic do_set,
                             input logic [15:0] d, input logic [1:0] m,
                             input logic [31:0] exp_word,
                             input int inj_start, input int inj_set,
                             input logic [15:0] inj_din);
        int cyc;
        int done_cyc;
        din   = d;
        mode  = m;
        set   = do_set;
        start = 1'b1;
        @(posedge clk);
        #1;
        set   = 1'b0;
        start = 1'b0;
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " ss"}, 32'(ss), 32'd0);
        done_cyc = -1;
        cyc      = 0;
        while (done_cyc < 0 && cyc < 400) begin
            @(posedge clk);
            cyc++;
            #1;
            start = (cyc == inj_start);
            set   = (cyc == inj_set);
            if (cyc == inj_set) begin
                din  = inj_din;
                mode = 2'd0;
            end
            if (done) done_cyc = cyc;
        end
        start = 1'b0;
        set   = 1'b0;
        check({tag, " done cycle"}, 32'(done_cyc), 32'(DONE_CYC));
        check({tag, " bits"}, 32'(mon_bits), 32'd32);
        check({tag, " bytes"}, mon_word, exp_word);
        @(posedge clk);
        #1;
        check({tag, " done pulse width"}, 32'(done), 32'd0);
        check({tag, " idle after"}, 32'(busy), 32'd0);
        check({tag, " ss after"}, 32'(ss), 32'd1);
    endtask

    initial begin
        int pulses;
        rst   = 1'b1;
        set   = 1'b0;
        start = 1'b0;
        din   = '0;
        mode  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst ss", 32'(ss), 32'd1);
        check("rst sclk", 32'(sclk), 32'd0);
        check("rst mosi", 32'(mosi), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst state", 32'(state), 32'd0);
        rst = 1'b0;
        #1;
`ifdef DISP_READBACK_EN
        check("rst rdata", rdata, 32'h0);
`endif

        // Start with no prior set: reset shadow (all zero digits, mode 0).
        run_frame("noset", 1'b0, 16'hFFFF, 2'd1, 32'h3F3F3F3F, -1, -1, 16'h0);

        // Set and start together: new data goes out.
        run_frame("hex", 1'b1, 16'h3210, 2'd0, 32'h4F5B063F, -1, -1, 16'h0);

        // Separate set cycle, then start with different din/mode on the pins.
        din  = 16'h3A1B;
        mode = 2'd1;
        set  = 1'b1;
        @(posedge clk);
        #1;
        set = 1'b0;
        run_frame("raw", 1'b0, 16'h0000, 2'd0, 32'h030A010B, -1, -1, 16'h0);

        // Leading-zero blanking.
        run_frame("lzb", 1'b1, 16'h0058, 2'd2, 32'h00006D7F, -1, -1, 16'h0);
        run_frame("lzb zero", 1'b1, 16'h0000, 2'd2, 32'h0000003F, -1, -1, 16'h0);

        // Test mode with start and set during the frame; both ignored.
        run_frame("test", 1'b1, 16'h1234, 2'd3, 32'hFFFFFFFF, 50, 60, 16'h9658);
        run_frame("test shadow", 1'b0, 16'h9658, 2'd0, 32'hFFFFFFFF, -1, -1, 16'h0);

        // Reset mid-frame.
        din   = 16'h3210;
        mode  = 2'd0;
        set   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        set   = 1'b0;
        start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        check("midrst ss before", 32'(ss), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst ss", 32'(ss), 32'd1);
        check("midrst sclk", 32'(sclk), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst state", 32'(state), 32'd0);
        pulses = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("midrst no done", 32'(pulses), 32'd0);
        run_frame("post rst", 1'b0, 16'hFFFF, 2'd1, 32'h3F3F3F3F, -1, -1, 16'h0);

`ifdef DISP_READBACK_EN
        rx_pat = 32'hA55AFF00;
        run_frame("readback", 1'b1, 16'h3210, 2'd0, 32'h4F5B063F, -1, -1, 16'h0);
        check("readback rdata", rdata, 32'hA55AFF00);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
